// File: rtl/load_data_align_pkg.sv
// Shared definitions for the load alignment unit:
// RISC-V load funct3 encodings, FSM states and access-size helpers.
package load_data_align_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ0,
    ST_WAIT0,
    ST_REQ1,
    ST_WAIT1,
    ST_RESP
  } state_e;

  function automatic logic [3:0] f3_size(input logic [2:0] f3);
    logic [3:0] size;
    case (f3[1:0])
      2'b00:   size = 4'd1;
      2'b01:   size = 4'd2;
      2'b10:   size = 4'd4;
      default: size = 4'd8;
    endcase
    return size;
  endfunction

  function automatic logic f3_legal(input logic [2:0] f3, input logic is64);
    logic ok;
    case (f3)
      F3_LD, F3_LWU: ok = is64;
      3'b111:        ok = 1'b0;
      default:       ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_data_align_extract.sv
// Combinational field extraction from a two-beat little-endian window,
// followed by zero or sign extension to XLEN.
module load_extract
  import load_data_align_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]               i_beat0,
  input  logic [XLEN-1:0]               i_beat1,
  input  logic [$clog2(XLEN/8)-1:0]     i_offset,
  input  logic [2:0]                    i_funct3,
  output logic [XLEN-1:0]               o_data
);

  logic [XLEN-1:0] w_field;

  assign w_field = XLEN'({i_beat1, i_beat0} >> {i_offset, 3'b000});

  // Sign extension is built at 64 bits and truncated so one expression serves both widths
  always_comb begin
    o_data = '0;
    case (i_funct3)
      F3_LB:   o_data = XLEN'({{56{w_field[7]}}, w_field[7:0]});
      F3_LH:   o_data = XLEN'({{48{w_field[15]}}, w_field[15:0]});
      F3_LW:   o_data = XLEN'({{32{w_field[31]}}, w_field[31:0]});
      F3_LD:   o_data = w_field;
      F3_LBU:  o_data = XLEN'(w_field[7:0]);
      F3_LHU:  o_data = XLEN'(w_field[15:0]);
      F3_LWU:  o_data = XLEN'(w_field[31:0]);
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/load_data_align.sv
// Load alignment unit: issues one or two aligned bus reads per load and
// returns the extracted, extended value (or a fault) to the consumer.
//
// state  | meaning
// IDLE   | ready for a new load request
// REQ0   | first bus read requested, waiting for mem_req_ready
// WAIT0  | waiting for first beat
// REQ1   | second bus read (misaligned split) requested
// WAIT1  | waiting for second beat
// RESP   | result held until rsp_ready
module load_data_align
  import load_data_align_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [2:0]      req_funct3,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_fault
);

  localparam int BYTES = XLEN / 8;
  localparam int OFFW  = $clog2(BYTES);

  state_e            r_state, w_next;
  logic [OFFW-1:0]   r_offset;
  logic [2:0]        r_funct3;
  logic              r_split;
  logic [XLEN-1:0]   r_mem_addr, r_beat0, r_rsp_data;
  logic              r_rsp_fault;

  logic [OFFW-1:0]   w_req_offset;
  logic              w_req_split, w_req_fault;
  logic [XLEN-1:0]   w_base, w_ext, w_ext_beat0, w_ext_beat1;

  assign w_req_offset = req_addr[OFFW-1:0];
  assign w_req_split  = (4'(w_req_offset) + f3_size(req_funct3)) > 4'(BYTES);
  assign w_req_fault  = !f3_legal(req_funct3, XLEN == 64) || (w_req_split && !ALLOW_MISALIGNED);
  assign w_base       = {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};

  // In WAIT1 the live bus data is the upper beat; otherwise it is beat 0
  assign w_ext_beat0  = (r_state == ST_WAIT1) ? r_beat0 : mem_rdata;
  assign w_ext_beat1  = (r_state == ST_WAIT1) ? mem_rdata : '0;

  load_extract #(.XLEN(XLEN)) u_extract (
    .i_beat0  (w_ext_beat0),
    .i_beat1  (w_ext_beat1),
    .i_offset (r_offset),
    .i_funct3 (r_funct3),
    .o_data   (w_ext)
  );

  always_comb begin
    w_next        = r_state;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    rsp_valid     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = w_req_fault ? ST_RESP : ST_REQ0;
      end
      ST_REQ0: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) w_next = ST_WAIT0;
      end
      ST_WAIT0: if (mem_rvalid) w_next = r_split ? ST_REQ1 : ST_RESP;
      ST_REQ1: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) w_next = ST_WAIT1;
      end
      ST_WAIT1: if (mem_rvalid) w_next = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_offset    <= '0;
      r_funct3    <= '0;
      r_split     <= 1'b0;
      r_mem_addr  <= '0;
      r_beat0     <= '0;
      r_rsp_data  <= '0;
      r_rsp_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: if (req_valid) begin
          r_offset    <= w_req_offset;
          r_funct3    <= req_funct3;
          r_split     <= w_req_split;
          r_mem_addr  <= w_base;
          r_rsp_fault <= w_req_fault;
          r_rsp_data  <= '0;
        end
        ST_WAIT0: if (mem_rvalid) begin
          r_beat0 <= mem_rdata;
          if (r_split) r_mem_addr <= r_mem_addr + XLEN'(BYTES);
          else         r_rsp_data <= w_ext;
        end
        ST_WAIT1: if (mem_rvalid) r_rsp_data <= w_ext;
        default: ;
      endcase
    end
  end

  assign mem_addr  = r_mem_addr;
  assign rsp_data  = r_rsp_data;
  assign rsp_fault = r_rsp_fault;

endmodule

// File: doc/load_data_align.md
LOAD_DATA_ALIGN -- requirements
Module: load_data_align

Interface
REQ-001 Parameter XLEN, default 32, sets the data path width; legal values are 32 and 64.
REQ-002 Parameter ALLOW_MISALIGNED, default 1; 1 splits misaligned loads into two bus beats, 0 faults them.
REQ-003 clk  input  1  the single clock of the block.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  a load request is present.
REQ-006 req_ready  output  1  the block can accept a request.
REQ-007 req_addr  input  XLEN  byte address of the load.
REQ-008 req_funct3  input  3  RISC-V load funct3: 000 LB, 001 LH, 010 LW, 011 LD (XLEN=64 only), 100 LBU, 101 LHU, 110 LWU (XLEN=64 only).
REQ-009 mem_req_valid  output  1  a bus read is requested.
REQ-010 mem_req_ready  input  1  the bus accepts the read.
REQ-011 mem_addr  output  XLEN  bus address, aligned to XLEN/8 bytes.
REQ-012 mem_rvalid  input  1  bus read data is valid.
REQ-013 mem_rdata  input  XLEN  bus read data, little-endian.
REQ-014 rsp_valid  output  1  the result is valid.
REQ-015 rsp_ready  input  1  the consumer accepts the result.
REQ-016 rsp_data  output  XLEN  the aligned, zero- or sign-extended load value.
REQ-017 rsp_fault  output  1  the request was misaligned with ALLOW_MISALIGNED=0, or used an illegal funct3.

Function
REQ-018 The FSM SHALL have states IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 IDLE: on req_valid, the block SHALL latch addr and funct3 and go to REQ0; if faulting, it SHALL go directly to RESP with rsp_fault=1 and rsp_data=0.
REQ-020 REQ0 and REQ1: mem_req_valid=1; the state SHALL advance to WAIT0 or WAIT1 on mem_req_ready; mem_addr SHALL be held stable while stalled.
REQ-021 The beat-0 address SHALL be addr with its low log2(XLEN/8) bits cleared; the beat-1 address SHALL be the beat-0 address + XLEN/8, wrapping modulo 2^XLEN.
REQ-022 A load SHALL be misaligned when its byte offset + access size > XLEN/8.
REQ-023 WAIT0: on mem_rvalid, the block SHALL capture mem_rdata and go to REQ1 if misaligned, else to RESP; WAIT1 SHALL capture the second beat and go to RESP.
REQ-024 Extraction: the block SHALL form {beat1, beat0} >> (8*offset) and keep the low 8/16/32/64 bits.
REQ-025 Unsigned variants and LD SHALL zero-extend; LB, LH and LW (at XLEN=64) SHALL sign-extend from the field MSB.
REQ-026 RESP: rsp_valid=1 with rsp_data and rsp_fault registered and stable; on rsp_ready the state SHALL return to IDLE.
REQ-027 Latency for an aligned load with mem_req_ready=1 and mem_rvalid arriving in the cycle after the bus handshake: request accepted in cycle N, rsp_valid in cycle N+3.
REQ-028 A misaligned load under the same bus timing SHALL give rsp_valid in cycle N+5.
REQ-029 mem_rvalid outside WAIT0 and WAIT1 SHALL be ignored, and req_valid outside IDLE SHALL be ignored.
REQ-030 Only one load SHALL be outstanding at a time; there is no request pipelining.

Reset
REQ-031 Asserting rst_n low SHALL force, asynchronously: state IDLE, req_ready=1, mem_req_valid=0, rsp_valid=0, rsp_fault=0, rsp_data=0, mem_addr=0.
REQ-032 Reset mid-transaction SHALL abandon the load; a late mem_rvalid after reset SHALL be ignored under REQ-029.

Structure
REQ-033 A shared package SHALL hold the funct3 load-encoding constants and the FSM state enum.
REQ-034 The extraction and extension of REQ-024/REQ-025 SHALL be one combinational sub-module, load_extract, parametrised by XLEN.

Verification
REQ-035 XLEN=32, LB at addr 0x103, beat 0xF0A1B2C3 -> mem_addr 0x100, rsp_data 0xFFFFFFF0 at N+3.
REQ-036 XLEN=32, LHU at addr 0x102, beat 0x8001ABCD -> rsp_data 0x00008001, rsp_fault 0.
REQ-037 XLEN=32, ALLOW_MISALIGNED=1, LW at addr 0x0FE, beats 0x11223344 then 0x55667788 -> mem_addr 0x0FC then 0x100, rsp_data 0x77881122 at N+5.
REQ-038 ALLOW_MISALIGNED=0, LH at addr 0x003 -> no mem_req_valid, rsp_fault 1, rsp_data 0.
REQ-039 XLEN=64, LW at addr 0x4, beat 0x80000000_00000000 -> rsp_data 0xFFFFFFFF80000000; LWU returns 0x0000000080000000.
REQ-040 rst_n pulsed low in WAIT0, then mem_rvalid -> outputs at reset values and no rsp_valid; rsp_ready held 0 for 5 cycles in RESP -> rsp_data stable throughout.
